// File: rtl/sprite_loader.sv
// Sprite RAM writer: packs a valid/ready byte stream into RGB444 pixels
// and writes them in raster order through a single RAM write port.
module sprite_loader #(
    parameter int unsigned SPRITE_WIDTH  = 100,
    parameter int unsigned SPRITE_HEIGHT = 75,
    parameter int unsigned ADDR_W        = 13
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [11:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic [6:0]        col,
    output logic [6:0]        row
);

    localparam int unsigned COL_W = 7;

    typedef enum logic [2:0] {
        IDLE,
        HI,
        LO,
        WR,
        DONE
    } state_t;

    state_t     state;
    state_t     state_d;
    logic [3:0] red;
    logic       xfer;
    logic       last_pix;
    logic       ready_d;
    logic       busy_d;
    logic       wr_en_d;
    logic       done_d;

    assign xfer     = byte_valid && byte_ready;
    assign last_pix = (col == COL_W'(SPRITE_WIDTH - 1)) && (row == COL_W'(SPRITE_HEIGHT - 1));

    // State register
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state; output flags are decoded from the next state so they register with it
    always_comb begin
        state_d = state;
        ready_d = 1'b0;
        busy_d  = 1'b0;
        wr_en_d = 1'b0;
        done_d  = 1'b0;
        case (state)
            IDLE: if (start && !abort) state_d = HI;
            HI: begin
                if (abort)     state_d = IDLE;
                else if (xfer) state_d = LO;
            end
            LO: begin
                if (abort)     state_d = IDLE;
                else if (xfer) state_d = WR;
            end
            WR: begin
                if (abort)         state_d = IDLE;
                else if (last_pix) state_d = DONE;
                else               state_d = HI;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == HI) || (state_d == LO);
        busy_d  = (state_d == HI) || (state_d == LO) || (state_d == WR);
        wr_en_d = (state_d == WR);
        done_d  = (state_d == DONE);
    end

    // Output flags, pixel assembly and raster counters
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            byte_ready <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            col        <= '0;
            row        <= '0;
            red        <= '0;
        end else begin
            byte_ready <= ready_d;
            wr_en      <= wr_en_d;
            busy       <= busy_d;
            done       <= done_d;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        col     <= '0;
                        row     <= '0;
                        wr_addr <= '0;
                    end
                end
                HI: if (xfer && !abort) red <= byte_in[3:0];
                LO: if (xfer && !abort) wr_data <= {red, byte_in};
                WR: begin
                    // Address holds at the final pixel so it never passes the last RAM entry
                    if (last_pix) begin
                        col <= '0;
                        row <= '0;
                    end else begin
                        wr_addr <= wr_addr + ADDR_W'(1);
                        if (col == COL_W'(SPRITE_WIDTH - 1)) begin
                            col <= '0;
                            row <= row + COL_W'(1);
                        end else begin
                            col <= col + COL_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_loader.sv
// Directed + randomized bench for sprite_loader; writes are compared against
// a raster-order pixel list built from the byte stream the bench sends.
module tb_sprite_loader;

    localparam int unsigned W    = 100;
    localparam int unsigned H    = 75;
    localparam int unsigned AW   = 13;
    localparam int unsigned NPIX = W * H;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [7:0]    byte_in = 8'h00;
    logic          byte_valid = 1'b0;
    logic          byte_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [11:0]   wr_data;
    logic          busy;
    logic          done;
    logic [6:0]    col;
    logic [6:0]    row;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [11:0]   data;
        logic [6:0]    col;
        logic [6:0]    row;
    } wr_t;

    wr_t wq[$];
    wr_t expq[$];
    int  done_cnt = 0;
    int  passed = 0;
    int  total = 0;
    int  tmo = 0;

    sprite_loader #(.SPRITE_WIDTH(W), .SPRITE_HEIGHT(H), .ADDR_W(AW)) dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .abort(abort),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .col(col), .row(row)
    );

    always #5 CLK = ~CLK;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance one clock and sample just after the edge
    task automatic tick();
        @(posedge CLK);
        #1;
        if (wr_en === 1'b1) wq.push_back('{wr_addr, wr_data, col, row});
        if (done === 1'b1) done_cnt++;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gaps);
        bit acc;
        acc = 1'b0;
        repeat (gaps) begin
            byte_valid = 1'b0;
            tick();
        end
        byte_valid = 1'b1;
        byte_in    = b;
        for (int k = 0; k < 40 && !acc; k++) begin
            acc = (byte_ready === 1'b1);
            tick();
        end
        byte_valid = 1'b0;
        if (!acc) tmo++;
    endtask

    // Reference pixel: raster position from the index, colour from the two bytes
    function automatic wr_t model_pix(input int idx, input logic [7:0] b1, input logic [7:0] b2);
        wr_t r;
        r.addr = AW'(idx);
        r.data = {b1[3:0], b2};
        r.col  = 7'(idx % W);
        r.row  = 7'(idx / W);
        return r;
    endfunction

    task automatic send_pixel(input int idx, input logic [7:0] b1, input logic [7:0] b2,
                              input int g1, input int g2);
        expq.push_back(model_pix(idx, b1, b2));
        send_byte(b1, g1);
        send_byte(b2, g2);
    endtask

    task automatic cmp_writes(input string tag);
        chk({tag, "_count"}, 64'(wq.size()), 64'(expq.size()));
        for (int i = 0; i < wq.size() && i < expq.size(); i++)
            chk(tag, 64'(wq[i]), 64'(expq[i]));
    endtask

    function automatic int rgap();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
    endfunction

    initial begin
        logic [7:0] b1, b2;
        int         d0;

        // Reset with byte_valid asserted
        RST_N = 1'b0;
        byte_valid = 1'b1;
        byte_in = 8'h55;
        tick();
        tick();
        chk("rst_byte_ready", 64'(byte_ready), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_wr_en", 64'(wr_en), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_addr", 64'(wr_addr), 0);
        chk("rst_data", 64'(wr_data), 0);
        chk("rst_colrow", 64'({col, row}), 0);
        chk("rst_no_write", 64'(wq.size()), 0);
        byte_valid = 1'b0;
        RST_N = 1'b1;
        tick();

        // Full load with random gaps and a stray start pulse mid-load
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", 64'(busy), 1);
        chk("start_ready", 64'(byte_ready), 1);
        for (int i = 0; i < int'(NPIX); i++) begin
            if (i == 0) begin
                b1 = 8'h0A; b2 = 8'hBC;
            end else if (i == 1) begin
                b1 = 8'hF1; b2 = 8'h23;
            end else begin
                b1 = 8'($urandom); b2 = 8'($urandom);
            end
            if (i == 3000) begin
                start = 1'b1;
                tick();
                start = 1'b0;
            end
            if (i < 101) send_pixel(i, b1, b2, 0, 0);
            else         send_pixel(i, b1, b2, rgap(), rgap());
            if (i == 0) begin
                chk("p0_wr_en", 64'(wr_en), 1);
                chk("p0_addr", 64'(wr_addr), 0);
                chk("p0_data", 64'(wr_data), 64'h0ABC);
                tick();
                chk("p0_wr_en_one_cycle", 64'(wr_en), 0);
            end
            if (i == 1) begin
                chk("p1_addr", 64'(wr_addr), 1);
                chk("p1_data", 64'(wr_data), 64'h123);
            end
            if (i == 99) begin
                chk("p99_addr", 64'(wr_addr), 99);
                chk("p99_colrow", 64'({col, row}), 64'({7'd99, 7'd0}));
            end
            if (i == 100) begin
                chk("p100_addr", 64'(wr_addr), 100);
                tick();
                chk("p100_after_colrow", 64'({col, row}), 64'({7'd1, 7'd1}));
            end
        end
        chk("last_wr_en", 64'(wr_en), 1);
        chk("last_addr", 64'(wr_addr), 64'(NPIX - 1));
        tick();
        chk("done_pulse", 64'(done), 1);
        chk("done_busy", 64'(busy), 0);
        chk("done_colrow", 64'({col, row}), 0);
        tick();
        chk("done_one_cycle", 64'(done), 0);
        chk("after_busy", 64'(busy), 0);
        chk("done_count", 64'(done_cnt), 1);
        cmp_writes("full_write");

        // Abort after five pixels and one byte
        wq.delete();
        expq.delete();
        d0 = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++)
            send_pixel(i, 8'($urandom), 8'($urandom), rgap(), rgap());
        send_byte(8'($urandom), 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 0);
        chk("abort_ready", 64'(byte_ready), 0);
        byte_valid = 1'b1;
        repeat (5) tick();
        byte_valid = 1'b0;
        cmp_writes("abort_write");
        chk("abort_no_done", 64'(done_cnt), 64'(d0));

        // Restart from address 0, then abort coinciding with the write cycle
        wq.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        send_byte(8'h95, 0);
        send_byte(8'h67, 0);
        chk("restart_addr", 64'(wr_addr), 0);
        chk("restart_data", 64'(wr_data), 64'h567);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("wr_abort_wr_en", 64'(wr_en), 0);
        chk("wr_abort_busy", 64'(busy), 0);
        chk("wr_abort_writes", 64'(wq.size()), 1);

        // start and abort together in IDLE
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", 64'(busy), 0);
        chk("start_abort_ready", 64'(byte_ready), 0);
        tick();
        chk("start_abort_idle", 64'(busy), 0);
        chk("byte_timeouts", 64'(tmo), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sprite_loader.md
Name: sprite_loader

Overview:
Writer side of the sprite pixel memory. Accepts a byte stream on a valid/ready handshake (e.g. from a UART receiver) and packs each pair of bytes into a 12-bit RGB444 pixel. Writes the pixels, in raster order, through a single write port into the SPRITE_WIDTH x SPRITE_HEIGHT sprite RAM that the sprite renderer reads. This lets the team replace sprite images at run time instead of only at initialisation.

Parameters:
SPRITE_WIDTH, 100, sprite columns
SPRITE_HEIGHT, 75, sprite rows
ADDR_W, 13, RAM address width; must satisfy 2^ADDR_W >= SPRITE_WIDTH*SPRITE_HEIGHT

Ports:
CLK  in  1  clock
RST_N  in  1  synchronous reset, active-low
start  in  1  begin a load; sampled only in IDLE
abort  in  1  cancel the load in progress
byte_in  in  8  stream byte
byte_valid  in  1  byte_in is valid
byte_ready  out  1  loader accepts byte_in this cycle
wr_en  out  1  RAM write strobe
wr_addr  out  ADDR_W  RAM write address = row*SPRITE_WIDTH + col
wr_data  out  12  RAM write data, RGB444
busy  out  1  load in progress
done  out  1  one-cycle pulse after the last pixel is written
col  out  7  column of the next pixel to write
row  out  7  row of the next pixel to write

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-low on RST_N.
- Reset (RST_N=0 at a rising edge): state=IDLE; all outputs 0 (byte_ready, wr_en, wr_addr, wr_data, busy, done, col, row).
- Registered outputs: all outputs come from registers; no combinational path from any input to any output.
- Byte transfer: a byte transfers only on an edge where byte_valid=1 and byte_ready=1.
- Byte order: first byte of a pixel is {xxxx, R[3:0]}; its upper nibble is ignored. Second byte is {G[3:0], B[3:0]}. wr_data = {R, G, B}.
- State IDLE: byte_ready=0, busy=0. If start=1: clear col, row and the address counter; go to HI.
- State HI: byte_ready=1, busy=1. On transfer: latch R; go to LO.
- State LO: byte_ready=1, busy=1. On transfer: latch G and B; go to WR.
- State WR (exactly one cycle):
  - wr_en=1, wr_addr = current address counter, wr_data = packed pixel, byte_ready=0.
  - On leaving WR: address +1 and col +1. If col was SPRITE_WIDTH-1, col wraps to 0 and row +1.
  - If this was pixel SPRITE_WIDTH*SPRITE_HEIGHT-1 (col=SPRITE_WIDTH-1, row=SPRITE_HEIGHT-1): go to DONE. Otherwise go to HI.
- State DONE (one cycle): done=1, busy=0, col=row=0; go to IDLE.
- wr_en is 0 in every state except WR.
- Timing: wr_en rises in the cycle immediately after the edge that accepts the second byte. Peak throughput is one pixel per 3 cycles; byte_valid gaps only stretch HI/LO.
- Address arithmetic: the address is an incrementing counter, not a multiply. It always equals row*SPRITE_WIDTH+col. Maximum value is SPRITE_WIDTH*SPRITE_HEIGHT-1; it never wraps past it.
- abort=1 in HI, LO or WR:
  - Go to IDLE at the next edge; wr_en=0 from that edge.
  - A WR cycle coinciding with abort still writes (the strobe is already registered). No further writes follow.
  - done is not pulsed.
- abort=1 in IDLE: no effect. If start and abort are both 1 in IDLE, abort wins and the loader stays in IDLE.
- start=1 outside IDLE: ignored.
- Incomplete pixel: a half-received pixel (HI done, LO pending) is discarded on abort or reset.
- Reset mid-load: returns to IDLE with no further writes. RAM contents already written remain.

Test Plan:
1. Reset with RST_N=0 for 2 cycles while byte_valid=1 -> byte_ready=0, busy=0, wr_en=0; no write occurs.
2. start, then bytes 0x0A, 0xBC with byte_valid held 1 -> wr_en=1 for exactly one cycle, wr_addr=0, wr_data=0xABC. Next pixel 0xF1, 0x23 -> wr_addr=1, wr_data=0x123 (upper nibble ignored).
3. Stream 100 pixels -> 100th write at wr_addr=99 with col=99, row=0 before the write. 101st write at wr_addr=100; after it col=1, row=1.
4. Full 7500-pixel load with random byte_valid gaps -> 7500 write strobes; addresses 0..7499 strictly sequential; data matches the stream; a single done pulse the cycle after the last write; busy=0 afterwards.
5. abort asserted after 5 pixels plus one byte -> IDLE next cycle, no 6th write, no done. A new start then writes from wr_addr=0.
6. start pulsed during a load -> ignored; addresses continue unbroken. start and abort together in IDLE -> remains IDLE.
